// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction-fetch controller: FSM states,
// the NOP encoding presented after reset, and the default PC vectors.
package fetch_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_DRAIN,
    ST_HOLD,
    ST_HALT
  } state_t;

  localparam logic [31:0] NOP_INSN             = 32'h0000_0013;
  localparam logic [31:0] DEFAULT_RESET_VECTOR = 32'h0000_0000;
  localparam logic [31:0] DEFAULT_TRAP_VECTOR  = 32'h0000_0010;
  localparam logic [31:0] INSN_BYTES           = 32'd4;

  // A fetch target is legal only on a 4-byte boundary.
  function automatic logic is_misaligned(input logic [31:0] addr);
    return addr[1:0] != 2'b00;
  endfunction

endpackage

// File: rtl/fetch_npc.sv
// Combinational next-PC candidates: the sequential successor of the
// address just fetched, and the redirect destination (or the trap vector
// when the requested target is not word aligned).
module fetch_npc
  import fetch_pkg::*;
#(
  parameter logic [31:0] TRAP_VECTOR = DEFAULT_TRAP_VECTOR
) (
  input  logic [31:0] base_pc,
  input  logic [31:0] redirect_target,
  output logic [31:0] seq_pc,
  output logic [31:0] redirect_pc,
  output logic        misaligned
);

  // 32-bit add wraps naturally past 32'hFFFF_FFFC.
  assign seq_pc      = base_pc + INSN_BYTES;
  assign misaligned  = is_misaligned(redirect_target);
  assign redirect_pc = misaligned ? TRAP_VECTOR : redirect_target;

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction-fetch controller. Issues one request at a time to the
// instruction memory, holds the returned word for decode until it is
// accepted, and handles redirects and halts. A redirect or halt that
// arrives while a request is outstanding without its response waits in
// DRAIN so the memory handshake always completes before a new address
// is presented.
module fetch_ctrl
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = DEFAULT_RESET_VECTOR,
  parameter logic [31:0] TRAP_VECTOR  = DEFAULT_TRAP_VECTOR
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        inst_valid,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  input  logic        inst_ready,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  input  logic        halt,
  output logic        halted,
  output logic        misalign_trap
);

  state_t      state;
  logic [31:0] pc;
  logic [31:0] req_addr;
  logic        halt_pending;

  logic [31:0] seq_pc;
  logic [31:0] redir_pc;
  logic        redir_bad;
  logic        pending_no_ack;

  fetch_npc #(
    .TRAP_VECTOR (TRAP_VECTOR)
  ) u_npc (
    .base_pc         (req_addr),
    .redirect_target (redirect_target),
    .seq_pc          (seq_pc),
    .redirect_pc     (redir_pc),
    .misaligned      (redir_bad)
  );

  // A request is on the bus only in REQ or DRAIN; the address is always
  // the registered request address so it cannot move mid-handshake.
  assign imem_req       = (state == ST_REQ) || (state == ST_DRAIN);
  assign imem_addr      = req_addr;
  assign halted         = (state == ST_HALT);
  assign pending_no_ack = imem_req && !imem_ack;

  // Fetch FSM and all architectural registers; priority rst > halt > redirect > normal flow.
  always_ff @(posedge clk) begin
    // NOTE: reset is sampled on the clock edge only, so every register
    // here (including the datapath words) gets an explicit value under rst.
    if (rst) begin
      // NOTE: non-blocking assignments keep every register reading the
      // pre-edge values of its neighbours, independent of statement order.
      state         <= ST_IDLE;
      pc            <= RESET_VECTOR;
      req_addr      <= RESET_VECTOR;
      halt_pending  <= 1'b0;
      inst_valid    <= 1'b0;
      inst          <= NOP_INSN;
      inst_pc       <= 32'h0000_0000;
      misalign_trap <= 1'b0;
    end else begin
      misalign_trap <= 1'b0;
      if (state != ST_HALT) begin
        if (halt) begin
          inst_valid <= 1'b0;
          if (pending_no_ack) begin
            // Let the outstanding response arrive, then stop.
            halt_pending <= 1'b1;
            state        <= ST_DRAIN;
          end else begin
            state <= ST_HALT;
          end
        end else if (redirect_valid) begin
          pc            <= redir_pc;
          inst_valid    <= 1'b0;
          misalign_trap <= redir_bad;
          if (pending_no_ack) begin
            // Old address stays on the bus until its response is drained.
            state <= ST_DRAIN;
          end else begin
            // Nothing in flight (or its response lands now and is dropped).
            req_addr <= redir_pc;
            state    <= (state == ST_DRAIN && halt_pending) ? ST_HALT : ST_REQ;
          end
        end else begin
          unique case (state)
            ST_IDLE: begin
              req_addr <= pc;
              state    <= ST_REQ;
            end
            ST_REQ: begin
              if (imem_ack) begin
                inst       <= imem_rdata;
                inst_pc    <= req_addr;
                inst_valid <= 1'b1;
                pc         <= seq_pc;
                state      <= ST_HOLD;
              end
            end
            ST_DRAIN: begin
              if (imem_ack) begin
                // Stale response discarded; pc already holds the new target.
                req_addr <= pc;
                state    <= halt_pending ? ST_HALT : ST_REQ;
              end
            end
            ST_HOLD: begin
              if (inst_ready) begin
                inst_valid <= 1'b0;
                req_addr   <= pc;
                state      <= ST_REQ;
              end
            end
            default: begin
              state <= state;
            end
          endcase
        end
      end
    end
  end

endmodule
